// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and width helper for the UART packet arbiter.
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_PKT_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: searches ptr+1, ptr+2, ... modulo N and
// returns the first asserted request. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [ID_W-1:0] o_sel,
    output logic            o_any
);

    logic [ID_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        o_sel = '0;
        o_any = 1'b0;
        w_idx = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = ID_W'((int'(i_ptr) + k) % N);
            if (i_req[w_idx]) begin
                o_sel = w_idx;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_pkt_arbiter.sv
// Round-robin scheduler sharing one byte-level UART transmitter among NUM_REQ
// packet sources; sends MSB byte first, enforces an idle gap and a done-watchdog.
module uart_pkt_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int PKT_BYTES  = DEF_PKT_BYTES,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*BYTE_W*PKT_BYTES-1:0] pkt_data,
    output logic [NUM_REQ-1:0]                  ack,
    output logic                                tx_send,
    output logic [BYTE_W-1:0]                   tx_data,
    input  logic                                tx_done,
    output logic                                busy,
    output logic [clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                pkt_done,
    output logic                                timeout_err
);

    localparam int PKT_W  = BYTE_W * PKT_BYTES;
    localparam int ID_W   = clog2(NUM_REQ);
    localparam int CNT_W  = clog2(PKT_BYTES) + 1;
    localparam int WDOG_W = clog2(TIMEOUT) + 1;
    localparam int GAP_W  = clog2(GAP_CYCLES) + 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(PKT_BYTES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [PKT_W-1:0]    r_shift;
    logic [CNT_W-1:0]    r_byte_cnt;
    logic [WDOG_W-1:0]   r_wdog;
    logic [GAP_W-1:0]    r_gap;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_tx_send;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_pkt_done;
    logic                r_timeout_err;

    logic [ID_W-1:0]     w_sel;
    logic                w_any;
    logic                w_grant;
    logic                w_advance;
    logic                w_last;
    logic                w_expire;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A tx_done in the expiry cycle takes precedence over the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_advance   = 1'b0;
        w_last      = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_last      = 1'b1;
                        w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = SEND;
                    end
                end else if (r_wdog == WDOG_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= ID_W'(NUM_REQ - 1);
            r_grant_id    <= '0;
            r_shift       <= '0;
            r_byte_cnt    <= '0;
            r_wdog        <= '0;
            r_gap         <= '0;
            r_ack         <= '0;
            r_tx_send     <= 1'b0;
            r_tx_data     <= '0;
            r_pkt_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_ack         <= '0;
            r_tx_send     <= 1'b0;
            r_pkt_done    <= w_last;
            r_timeout_err <= w_expire;
            if (w_grant) begin
                r_ack      <= NUM_REQ'(1) << w_sel;
                r_grant_id <= w_sel;
                r_ptr      <= w_sel;
                r_shift    <= pkt_data[int'(w_sel)*PKT_W +: PKT_W];
                r_byte_cnt <= '0;
            end
            if (r_state == SEND) begin
                r_tx_send <= 1'b1;
                r_tx_data <= r_shift[PKT_W-1 -: BYTE_W];
                r_wdog    <= '0;
            end
            if (r_state == WAIT) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_advance) begin
                r_shift    <= r_shift << BYTE_W;
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (w_last) begin
                r_gap <= '0;
            end else if (r_state == GAP) begin
                r_gap <= r_gap + 1'b1;
            end
        end
    end

    assign ack         = r_ack;
    assign tx_send     = r_tx_send;
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != IDLE);
    assign grant_id    = r_grant_id;
    assign pkt_done    = r_pkt_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_pkt_arbiter.sv
// Directed bench for uart_pkt_arbiter with a delayed-done transmitter model,
// a negedge monitor and a byte scoreboard.
module tb_uart_pkt_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int PKT_BYTES  = 16;
    localparam int GAP_CYCLES = 4;
    localparam int TIMEOUT    = 64;
    localparam int DONE_DLY   = 10;
    localparam int PKT_W      = 8 * PKT_BYTES;

    localparam logic [PKT_W-1:0] PKT0 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [PKT_W-1:0] PKT1 = 128'h101112131415161718191A1B1C1D1E1F;
    localparam logic [PKT_W-1:0] PKT2 = 128'h202122232425262728292A2B2C2D2E2F;
    localparam logic [PKT_W-1:0] PKT3 = 128'h303132333435363738393A3B3C3D3E3F;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ*PKT_W-1:0]   pkt_data = '0;
    logic [NUM_REQ-1:0]         ack;
    logic                       tx_send;
    logic [7:0]                 tx_data;
    logic                       tx_done;
    logic                       busy;
    logic [1:0]                 grant_id;
    logic                       pkt_done;
    logic                       timeout_err;
    logic                       xm_done = 1'b0;
    logic                       spur_done = 1'b0;

    assign tx_done = xm_done | spur_done;

    uart_pkt_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .PKT_BYTES  (PKT_BYTES),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .pkt_data    (pkt_data),
        .ack         (ack),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .pkt_done    (pkt_done),
        .timeout_err (timeout_err)
    );

    // ---------------- clock / cycle counter ----------------
    int cyc = 0;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got cycle %0d expected finish earlier", cyc);
        $fatal(1, "bench did not finish");
    end

    // ---------------- transmitter model ----------------
    int hold_byte = -1;
    int xm_cnt    = 0;
    int xm_bidx   = 0;
    initial forever begin
        @(posedge clk);
        #1;
        xm_done = 1'b0;
        if (!rst_n) begin
            xm_cnt  = 0;
            xm_bidx = 0;
        end else begin
            if (xm_cnt > 0) begin
                xm_cnt--;
                if (xm_cnt == 0) xm_done = 1'b1;
            end
            if (|ack) xm_bidx = 0;
            if (tx_send) begin
                if (xm_bidx != hold_byte) xm_cnt = DONE_DLY;
                xm_bidx++;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int ack_bad, overlap_err, pkt_done_cnt, to_cnt;
    int first_send_cyc, send_cyc, done_cyc, pkt_done_cyc, to_cyc, busy_fall_cyc;
    bit pending, prev_busy;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pending   = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (|ack && !$onehot(ack)) ack_bad++;
            if (tx_send) begin
                if (pending) overlap_err++;
                pending = 1'b1;
                if (got_q.size() == 0) first_send_cyc = cyc;
                send_cyc = cyc;
                got_q.push_back(tx_data);
            end
            if (tx_done && pending) begin
                pending  = 1'b0;
                done_cyc = cyc;
            end
            if (pkt_done) begin
                pkt_done_cnt++;
                pkt_done_cyc = cyc;
            end
            if (timeout_err) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_busy = busy;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input int src, input int k);
        logic [3:0] hi;
        logic [3:0] lo;
        if (src == 0) return 8'(k * 17);
        hi = 4'(src);
        lo = 4'(k);
        return {hi, lo};
    endfunction

    task automatic push_exp(input int src, input int nbytes);
        for (int k = 0; k < nbytes; k++) exp_q.push_back(pkt_byte(src, k));
    endtask

    task automatic check_bytes(input string tag);
        check_eq($sformatf("%s_len", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        exp_q.delete();
        ack_bad = 0; overlap_err = 0; pkt_done_cnt = 0; to_cnt = 0;
        first_send_cyc = -1; send_cyc = -1; done_cyc = -1;
        pkt_done_cyc = -1; to_cyc = -1; busy_fall_cyc = -1;
        pending = 1'b0;
    endtask

    task automatic wait_ack(input string tag, output int idx, output int a_cyc);
        bit ok;
        ok = 1'b0;
        idx = -1;
        a_cyc = -1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (|ack) begin
                for (int j = 0; j < NUM_REQ; j++) if (ack[j]) idx = j;
                a_cyc = cyc;
                ok = 1'b1;
            end
        end
        check_eq({tag, "_ack_seen"}, ok, 1'b1);
    endtask

    task automatic wait_end(input string tag, input int n_end);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            if ((pkt_done_cnt + to_cnt) >= n_end && !busy) ok = 1'b1;
        end
        check_eq({tag, "_end_seen"}, ok, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        step(3);
        rst_n = 1'b1;
        clear_logs();
        step(1);
    endtask

    // ---------------- stimulus ----------------
    int idx, a_cyc, req_cyc;
    int grants[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bit found;

    initial begin
        clear_logs();
        step(2);
        check_eq("rst_ack", ack, 4'b0000);
        check_eq("rst_tx_send", tx_send, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_grant_id", grant_id, 2'd0);
        check_eq("rst_pkt_done", pkt_done, 1'b0);
        check_eq("rst_timeout_err", timeout_err, 1'b0);
        rst_n = 1'b1;
        step(1);
        clear_logs();

        // single source, full packet
        pkt_data[0 +: PKT_W] = PKT0;
        req = 4'b0001;
        req_cyc = cyc;
        wait_ack("t1", idx, a_cyc);
        check_eq("t1_ack_idx", idx, 0);
        check_eq("t1_ack_lat", a_cyc - req_cyc, 1);
        check_eq("t1_grant_id", grant_id, 2'd0);
        check_eq("t1_busy", busy, 1'b1);
        req = '0;
        wait_end("t1", 1);
        check_eq("t1_first_send", first_send_cyc, a_cyc + 1);
        check_eq("t1_pkt_done_cnt", pkt_done_cnt, 1);
        check_eq("t1_pkt_done_cyc", pkt_done_cyc, done_cyc + 1);
        check_eq("t1_busy_fall", busy_fall_cyc, done_cyc + GAP_CYCLES + 1);
        check_eq("t1_timeouts", to_cnt, 0);
        push_exp(0, PKT_BYTES);
        check_bytes("t1");

        // all four requesting continuously
        do_reset();
        pkt_data = {PKT3, PKT2, PKT1, PKT0};
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_ack("t2", idx, a_cyc);
            grants[n] = idx;
        end
        req = '0;
        wait_end("t2", 5);
        for (int n = 0; n < 5; n++) begin
            check_eq($sformatf("t2_grant%0d", n), grants[n], exp_order[n]);
            push_exp(exp_order[n], PKT_BYTES);
        end
        check_eq("t2_ack_onehot", ack_bad, 0);
        check_eq("t2_overlap", overlap_err, 0);
        check_eq("t2_pkt_done_cnt", pkt_done_cnt, 5);
        check_bytes("t2");

        // pointer=1, then 0101 gives 2 before 0
        clear_logs();
        req = 4'b0010;
        wait_ack("t3a", idx, a_cyc);
        check_eq("t3_first_idx", idx, 1);
        req = '0;
        wait_end("t3a", 1);
        req = 4'b0101;
        wait_ack("t3b", idx, a_cyc);
        check_eq("t3_second_idx", idx, 2);
        req[2] = 1'b0;
        wait_ack("t3c", idx, a_cyc);
        check_eq("t3_third_idx", idx, 0);
        req = '0;
        wait_end("t3", 3);
        check_eq("t3_pkt_done_cnt", pkt_done_cnt, 3);

        // watchdog abort on byte 5
        clear_logs();
        hold_byte = 5;
        req = 4'b1000;
        wait_ack("t4", idx, a_cyc);
        check_eq("t4_ack_idx", idx, 3);
        req = '0;
        wait_end("t4", 1);
        check_eq("t4_to_cnt", to_cnt, 1);
        check_eq("t4_to_delay", to_cyc - send_cyc, TIMEOUT);
        check_eq("t4_no_pkt_done", pkt_done_cnt, 0);
        check_eq("t4_busy_fall", busy_fall_cyc, to_cyc);
        push_exp(3, 6);
        check_bytes("t4");
        hold_byte = -1;
        clear_logs();
        req = 4'b0001;
        wait_ack("t4n", idx, a_cyc);
        check_eq("t4n_ack_idx", idx, 0);
        req = '0;
        wait_end("t4n", 1);
        check_eq("t4n_pkt_done_cnt", pkt_done_cnt, 1);
        push_exp(0, PKT_BYTES);
        check_bytes("t4n");

        // spurious tx_done in GAP/IDLE, pkt_data change after ack
        clear_logs();
        pkt_data[PKT_W +: PKT_W] = PKT1;
        req = 4'b0010;
        wait_ack("t5", idx, a_cyc);
        check_eq("t5_ack_idx", idx, 1);
        req = '0;
        pkt_data[PKT_W +: PKT_W] = '1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (pkt_done_cnt > 0) found = 1'b1;
        end
        check_eq("t5_pkt_done_seen", found, 1'b1);
        step(1);
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        wait_end("t5", 1);
        step(1);
        spur_done = 1'b1;
        step(1);
        spur_done = 1'b0;
        step(20);
        check_eq("t5_busy_idle", busy, 1'b0);
        check_eq("t5_pkt_done_cnt", pkt_done_cnt, 1);
        push_exp(1, PKT_BYTES);
        check_bytes("t5");

        // reset in the middle of byte 8
        clear_logs();
        pkt_data = {PKT3, PKT2, PKT1, PKT0};
        req = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk);
            #2;
            if (tx_send === 1'b1 && tx_data === 8'h28) found = 1'b1;
        end
        check_eq("t6_byte8_seen", found, 1'b1);
        check_eq("t6_pre_grant_id", grant_id, 2'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tx_send", tx_send, 1'b0);
        check_eq("t6_rst_busy", busy, 1'b0);
        check_eq("t6_rst_grant_id", grant_id, 2'd0);
        check_eq("t6_rst_ack", ack, 4'b0000);
        check_eq("t6_rst_tx_data", tx_data, 8'h00);
        req = 4'b0101;
        step(3);
        clear_logs();
        rst_n = 1'b1;
        wait_ack("t6", idx, a_cyc);
        check_eq("t6_ack_idx", idx, 0);
        req = '0;
        wait_end("t6", 1);
        check_eq("t6_pkt_done_cnt", pkt_done_cnt, 1);
        push_exp(0, PKT_BYTES);
        check_bytes("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
